// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op codes, access sizes, error codes and FSM states.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic is_store(lsu_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic lsu_size_e op_size(lsu_op_e op);
    lsu_size_e sz;
    case (op)
      OP_LW, OP_SW:          sz = SZ_WORD;
      OP_LH, OP_LHU, OP_SH:  sz = SZ_HALF;
      default:               sz = SZ_BYTE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, replicated store data,
// extended load data and the alignment check for one access.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addrLo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdataRep,
  output logic [31:0] o_rdataExt,
  output logic        o_misaligned
);

  lsu_op_e     w_op;
  lsu_size_e   w_size;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_op      = lsu_op_e'(i_op);
  assign w_size    = op_size(w_op);
  assign w_shifted = i_rdata >> {i_addrLo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  assign o_misaligned = ((w_size == SZ_WORD) && (i_addrLo != 2'b00)) ||
                        ((w_size == SZ_HALF) && i_addrLo[0]);

  always_comb begin
    o_be       = 4'b1111;
    o_wdataRep = i_wdata;
    o_rdataExt = 32'd0;
    case (w_op)
      OP_LW:   o_rdataExt = i_rdata;
      OP_LH:   o_rdataExt = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_rdataExt = {16'd0, w_half};
      OP_LB:   o_rdataExt = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_rdataExt = {24'd0, w_byte};
      OP_SH: begin
        o_be       = i_addrLo[1] ? 4'b1100 : 4'b0011;
        o_wdataRep = {2{i_wdata[15:0]}};
      end
      OP_SB: begin
        o_be       = 4'b0001 << i_addrLo;
        o_wdataRep = {4{i_wdata[7:0]}};
      end
      default: o_rdataExt = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit front end: accepts one pipeline request at a time and
// drives a ready/ack word-addressed memory port, with alignment and timeout errors.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       r_state;
  logic [2:0]       r_op;
  logic [1:0]       r_addrLo;
  logic [CNT_W-1:0] r_count;
  logic             r_memReq;
  logic             r_memWe;
  logic [31:0]      r_memAddr;
  logic [3:0]       r_memBe;
  logic [31:0]      r_memWdata;
  logic             r_respValid;
  logic [31:0]      r_respRdata;
  logic [1:0]       r_respErr;

  logic [2:0]       w_alignOp;
  logic [1:0]       w_alignAddrLo;
  logic [3:0]       w_be;
  logic [31:0]      w_wdataRep;
  logic [31:0]      w_rdataExt;
  logic             w_misaligned;

  // In IDLE the lane logic looks at the incoming request; afterwards at the captured one.
  assign w_alignOp     = (r_state == ST_IDLE) ? req_op : r_op;
  assign w_alignAddrLo = (r_state == ST_IDLE) ? req_addr[1:0] : r_addrLo;

  lsu_lane_align u_laneAlign (
    .i_op         (w_alignOp),
    .i_addrLo     (w_alignAddrLo),
    .i_wdata      (req_wdata),
    .i_rdata      (mem_rdata),
    .o_be         (w_be),
    .o_wdataRep   (w_wdataRep),
    .o_rdataExt   (w_rdataExt),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_op        <= 3'd0;
      r_addrLo    <= 2'd0;
      r_count     <= '0;
      r_memReq    <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= 32'd0;
      r_memBe     <= 4'd0;
      r_memWdata  <= 32'd0;
      r_respValid <= 1'b0;
      r_respRdata <= 32'd0;
      r_respErr   <= ERR_OK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_respValid <= 1'b0;
          if (req_valid) begin
            r_op     <= req_op;
            r_addrLo <= req_addr[1:0];
            if (w_misaligned) begin
              r_respValid <= 1'b1;
              r_respErr   <= ERR_ALIGN;
              r_respRdata <= 32'd0;
              r_state     <= ST_RESP;
            end else begin
              r_memAddr  <= {req_addr[31:2], 2'b00};
              r_memBe    <= w_be;
              r_memWdata <= w_wdataRep;
              r_memWe    <= is_store(lsu_op_e'(req_op));
              r_memReq   <= 1'b1;
              r_count    <= '0;
              r_state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // An ack arriving on the last allowed cycle still completes normally.
          if (mem_ack) begin
            r_memReq    <= 1'b0;
            r_respRdata <= w_rdataExt;
            r_respErr   <= ERR_OK;
            r_respValid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (r_count == TimeoutLast) begin
            r_memReq    <= 1'b0;
            r_respRdata <= 32'd0;
            r_respErr   <= ERR_TIMEOUT;
            r_respValid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_RESP: begin
          r_respValid <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_memReq    <= 1'b0;
          r_respValid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign mem_req    = r_memReq;
  assign mem_we     = r_memWe;
  assign mem_addr   = r_memAddr;
  assign mem_be     = r_memBe;
  assign mem_wdata  = r_memWdata;
  assign resp_valid = r_respValid;
  assign resp_rdata = r_respRdata;
  assign resp_err   = r_respErr;

endmodule
